// File: rtl/sync_fifo_param_pkg.sv
// Shared constants and elaboration helpers for the parametrised synchronous FIFO.
package sync_fifo_param_pkg;

    localparam int unsigned DEF_DATA_W   = 8;
    localparam int unsigned DEF_DEPTH    = 8;
    localparam int unsigned DEF_AF_LEVEL = 6;
    localparam int unsigned DEF_AE_LEVEL = 1;

    // Smallest width able to index 'value' entries.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned width;
        width = 0;
        while ((32'd1 << width) < value) begin
            width++;
        end
        return width;
    endfunction

    function automatic bit is_pow2(input int unsigned value);
        return (value != 0) && ((value & (value - 1)) == 0);
    endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// DEPTH x DATA_W simple dual-port storage: synchronous write, asynchronous read.
module sync_fifo_ram #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned ADDR_W = 3
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy flags, overflow/underflow pulses
// and optional first-word-fall-through read mode.
module sync_fifo_param
    import sync_fifo_param_pkg::*;
#(
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned DEPTH    = DEF_DEPTH,
    parameter int unsigned AF_LEVEL = DEF_AF_LEVEL,
    parameter int unsigned AE_LEVEL = DEF_AE_LEVEL,
    parameter int unsigned FWFT     = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      wr,
    input  logic [DATA_W-1:0]         din,
    input  logic                      rd,
    output logic [DATA_W-1:0]         dout,
    output logic                      full,
    output logic                      empty,
    output logic                      almost_full,
    output logic                      almost_empty,
    output logic                      overflow,
    output logic                      underflow,
    output logic [clog2(DEPTH):0]     fifo_cnt
);

    localparam int unsigned PTR_W = clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    if (DATA_W < 1) begin : g_bad_width
        $error("sync_fifo_param: DATA_W must be >= 1");
    end
    if (DEPTH < 2 || !is_pow2(DEPTH)) begin : g_bad_depth
        $error("sync_fifo_param: DEPTH must be a power of two >= 2");
    end
    if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
        $error("sync_fifo_param: AF_LEVEL must be within 1..DEPTH");
    end
    if (AE_LEVEL > DEPTH - 1) begin : g_bad_ae
        $error("sync_fifo_param: AE_LEVEL must be within 0..DEPTH-1");
    end

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              overflow_q, underflow_q;
    logic              wr_acc, rd_acc;
    logic [DATA_W-1:0] ram_rdata;

    // Flags decode straight from the registered count.
    assign full         = (cnt_q == CNT_W'(DEPTH));
    assign empty        = (cnt_q == '0);
    assign almost_full  = (cnt_q >= CNT_W'(AF_LEVEL));
    assign almost_empty = (cnt_q <= CNT_W'(AE_LEVEL));
    assign fifo_cnt     = cnt_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    assign wr_acc = wr & ~full;
    assign rd_acc = rd & ~empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({wr_acc, rd_acc})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Sole owner of pointers, occupancy and the rejection pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            overflow_q  <= wr & full;
            underflow_q <= rd & empty;
        end
    end

    sync_fifo_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (PTR_W)
    ) u_ram (
        .clk     (clk),
        .we_i    (wr_acc),
        .waddr_i (wr_ptr_q),
        .wdata_i (din),
        .raddr_i (rd_ptr_q),
        .rdata_o (ram_rdata)
    );

    if (FWFT != 0) begin : g_fwft
        // Head word is presented as soon as it is stored; meaningless while empty.
        assign dout = ram_rdata;
    end else begin : g_std
        logic [DATA_W-1:0] dout_q;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                dout_q <= '0;
            end else if (rd_acc) begin
                dout_q <= ram_rdata;
            end
        end

        assign dout = dout_q;
    end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: default-config instance plus an FWFT/DEPTH=16/DATA_W=12 instance.
module tb_sync_fifo_param;

    logic        clk;
    logic        reset;

    logic        wr_a, rd_a;
    logic [7:0]  din_a, dout_a;
    logic        full_a, empty_a, af_a, ae_a, ovf_a, unf_a;
    logic [3:0]  cnt_a;

    logic        wr_b, rd_b;
    logic [11:0] din_b, dout_b;
    logic        full_b, empty_b, af_b, ae_b, ovf_b, unf_b;
    logic [4:0]  cnt_b;

    int checks = 0;
    int errors = 0;
    logic run_chk = 1'b0;

    sync_fifo_param u_dut_a (
        .clk          (clk),
        .reset        (reset),
        .wr           (wr_a),
        .din          (din_a),
        .rd           (rd_a),
        .dout         (dout_a),
        .full         (full_a),
        .empty        (empty_a),
        .almost_full  (af_a),
        .almost_empty (ae_a),
        .overflow     (ovf_a),
        .underflow    (unf_a),
        .fifo_cnt     (cnt_a)
    );

    sync_fifo_param #(
        .DATA_W (12),
        .DEPTH  (16),
        .FWFT   (1)
    ) u_dut_b (
        .clk          (clk),
        .reset        (reset),
        .wr           (wr_b),
        .din          (din_b),
        .rd           (rd_b),
        .dout         (dout_b),
        .full         (full_b),
        .empty        (empty_b),
        .almost_full  (af_b),
        .almost_empty (ae_b),
        .overflow     (ovf_b),
        .underflow    (unf_b),
        .fifo_cnt     (cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain queues, evaluated on the pre-edge occupancy.
    logic [7:0]  qa[$];
    logic [11:0] qb[$];
    logic [7:0]  m_dout_a;
    logic        m_ovf_a, m_unf_a, m_ovf_b, m_unf_b;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            qa.delete();
            qb.delete();
            m_dout_a = 8'h00;
            m_ovf_a  = 1'b0;
            m_unf_a  = 1'b0;
            m_ovf_b  = 1'b0;
            m_unf_b  = 1'b0;
        end else begin
            m_ovf_a = wr_a && (qa.size() == 8);
            m_unf_a = rd_a && (qa.size() == 0);
            m_ovf_b = wr_b && (qb.size() == 16);
            m_unf_b = rd_b && (qb.size() == 0);
            if (rd_a && !m_unf_a) m_dout_a = qa.pop_front();
            if (wr_a && !m_ovf_a) qa.push_back(din_a);
            if (rd_b && !m_unf_b) void'(qb.pop_front());
            if (wr_b && !m_ovf_b) qb.push_back(din_b);
        end
    end

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (run_chk) begin
            chk("a_cnt",   32'(cnt_a),   32'(qa.size()));
            chk("a_full",  32'(full_a),  32'(qa.size() == 8));
            chk("a_empty", 32'(empty_a), 32'(qa.size() == 0));
            chk("a_af",    32'(af_a),    32'(qa.size() >= 6));
            chk("a_ae",    32'(ae_a),    32'(qa.size() <= 1));
            chk("a_ovf",   32'(ovf_a),   32'(m_ovf_a));
            chk("a_unf",   32'(unf_a),   32'(m_unf_a));
            chk("a_dout",  32'(dout_a),  32'(m_dout_a));
            chk("b_cnt",   32'(cnt_b),   32'(qb.size()));
            chk("b_full",  32'(full_b),  32'(qb.size() == 16));
            chk("b_empty", 32'(empty_b), 32'(qb.size() == 0));
            chk("b_af",    32'(af_b),    32'(qb.size() >= 6));
            chk("b_ae",    32'(ae_b),    32'(qb.size() <= 1));
            chk("b_ovf",   32'(ovf_b),   32'(m_ovf_b));
            chk("b_unf",   32'(unf_b),   32'(m_unf_b));
            if (qb.size() != 0) chk("b_dout", 32'(dout_b), 32'(qb[0]));
        end
    end

    task automatic step_a(input logic w, input logic [7:0] d, input logic r);
        wr_a = w; din_a = d; rd_a = r;
        @(posedge clk);
        @(negedge clk);
        wr_a = 1'b0; rd_a = 1'b0;
    endtask

    task automatic step_b(input logic w, input logic [11:0] d, input logic r);
        wr_b = w; din_b = d; rd_b = r;
        @(posedge clk);
        @(negedge clk);
        wr_b = 1'b0; rd_b = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        wr_a = 1'b0; rd_a = 1'b0; din_a = 8'h00;
        wr_b = 1'b0; rd_b = 1'b0; din_b = 12'h000;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("rst_cnt",   32'(cnt_a),   32'd0);
        chk("rst_empty", 32'(empty_a), 32'd1);
        chk("rst_full",  32'(full_a),  32'd0);
        chk("rst_ae",    32'(ae_a),    32'd1);
        chk("rst_af",    32'(af_a),    32'd0);
        chk("rst_ovf",   32'(ovf_a),   32'd0);
        chk("rst_unf",   32'(unf_a),   32'd0);
        chk("rst_dout",  32'(dout_a),  32'd0);
        run_chk = 1'b1;

        // Fill to full, reject a ninth write, drain in order.
        for (int i = 1; i <= 8; i++) begin
            step_a(1'b1, 8'(i), 1'b0);
            chk("fill_cnt",  32'(cnt_a),  32'(i));
            chk("fill_af",   32'(af_a),   32'(i >= 6));
            chk("fill_full", 32'(full_a), 32'(i == 8));
        end
        step_a(1'b1, 8'hFF, 1'b0);
        chk("ovf_pulse", 32'(ovf_a), 32'd1);
        chk("ovf_cnt",   32'(cnt_a), 32'd8);
        step_a(1'b0, 8'h00, 1'b0);
        chk("ovf_clear", 32'(ovf_a), 32'd0);
        for (int i = 1; i <= 8; i++) begin
            step_a(1'b0, 8'h00, 1'b1);
            chk("drain_dout", 32'(dout_a), 32'(i));
        end
        chk("drain_empty", 32'(empty_a), 32'd1);

        // Read while empty.
        step_a(1'b0, 8'h00, 1'b1);
        chk("unf_pulse", 32'(unf_a),  32'd1);
        chk("unf_dout",  32'(dout_a), 32'h08);
        chk("unf_cnt",   32'(cnt_a),  32'd0);
        step_a(1'b0, 8'h00, 1'b0);
        chk("unf_clear", 32'(unf_a), 32'd0);

        // Steady-state simultaneous read/write across pointer wrap.
        for (int i = 0; i < 4; i++) step_a(1'b1, 8'(8'hA0 + i), 1'b0);
        for (int i = 0; i < 12; i++) begin
            step_a(1'b1, 8'(8'h10 + i), 1'b1);
            chk("ss_cnt",  32'(cnt_a),  32'd4);
            chk("ss_dout", 32'(dout_a), (i < 4) ? 32'(8'hA0 + i) : 32'(8'h10 + i - 4));
        end
        for (int i = 0; i < 4; i++) begin
            step_a(1'b0, 8'h00, 1'b1);
            chk("ss_tail", 32'(dout_a), 32'(8'h18 + i));
        end

        // Full with read+write: write rejected, read served.
        for (int i = 0; i < 8; i++) step_a(1'b1, 8'(8'h30 + i), 1'b0);
        step_a(1'b1, 8'hEE, 1'b1);
        chk("fullrw_cnt",  32'(cnt_a),  32'd7);
        chk("fullrw_ovf",  32'(ovf_a),  32'd1);
        chk("fullrw_dout", 32'(dout_a), 32'h30);
        for (int i = 0; i < 7; i++) begin
            step_a(1'b0, 8'h00, 1'b1);
            chk("fullrw_drain", 32'(dout_a), 32'(8'h31 + i));
        end
        // Empty with read+write: read rejected, write kept.
        step_a(1'b1, 8'h5A, 1'b1);
        chk("emptyrw_cnt", 32'(cnt_a), 32'd1);
        chk("emptyrw_unf", 32'(unf_a), 32'd1);
        step_a(1'b0, 8'h00, 1'b1);
        chk("emptyrw_dout", 32'(dout_a), 32'h5A);

        // Asynchronous reset between edges with five words stored.
        for (int i = 0; i < 5; i++) step_a(1'b1, 8'(8'h61 + i), 1'b0);
        chk("pre_rst_cnt", 32'(cnt_a), 32'd5);
        run_chk = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("arst_cnt",   32'(cnt_a),   32'd0);
        chk("arst_empty", 32'(empty_a), 32'd1);
        chk("arst_full",  32'(full_a),  32'd0);
        chk("arst_ae",    32'(ae_a),    32'd1);
        chk("arst_af",    32'(af_a),    32'd0);
        chk("arst_dout",  32'(dout_a),  32'd0);
        chk("arst_ovf",   32'(ovf_a),   32'd0);
        chk("arst_unf",   32'(unf_a),   32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1 run_chk = 1'b1;
        step_a(1'b1, 8'hA5, 1'b0);
        step_a(1'b0, 8'h00, 1'b1);
        chk("post_rst_dout", 32'(dout_a), 32'hA5);

        // FWFT instance: fall-through without a read, then random traffic.
        step_b(1'b1, 12'h3C5, 1'b0);
        chk("fwft_empty", 32'(empty_b), 32'd0);
        chk("fwft_dout",  32'(dout_b),  32'h3C5);
        step_b(1'b0, 12'h000, 1'b1);
        chk("fwft_pop", 32'(empty_b), 32'd1);
        for (int i = 0; i < 40; i++) begin
            logic w, r;
            w = (i < 24) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            r = (i < 24) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            step_b(w, 12'($urandom), r);
        end
        step_b(1'b0, 12'h000, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
